// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: tag entries,
// select width helper, multi-cycle FSM states and the producer match rule.
package hazard_pkg;

    // Tag register fields are sized for the widest supported RA_W.
    localparam int RA_MAX = 8;
    localparam int SEL_RF = 0;

    typedef logic [RA_MAX-1:0] ra_t;

    typedef struct packed {
        logic v;
        ra_t  rd;
        logic rw;
        logic ld;
        logic st;
        logic mc;
        ra_t  rs1;
        ra_t  rs2;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mc_state_t;

    function automatic int sel_w(input int fs);
        return (fs < 1) ? 1 : $clog2(fs + 1);
    endfunction

    // A live entry that writes a non-zero rd equal to r.
    function automatic logic tag_match(input tag_t e, input ra_t r);
        return e.v & e.rw & (e.rd != '0) & (e.rd == r);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage hazard bundle: instruction fields and flush from the pipeline,
// stall/hold/bypass selects and stall counter back from the controller.
interface hazard_forward_ctrl_if
    import hazard_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 32
);
    localparam int SELW = sel_w(FWD_STAGES);

    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use1;
    logic            id_use2;
    logic [RA_W-1:0] id_rd;
    logic            id_rw;
    logic            id_load;
    logic            id_store;
    logic            id_br;
    logic            id_mc;
    logic            flush;

    logic             stall;
    logic             hold;
    logic [SELW-1:0]  fwd_a;
    logic [SELW-1:0]  fwd_b;
    logic             fwd_br_a;
    logic             fwd_br_b;
    logic             fwd_m;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2,
        output id_use1, id_use2, id_rd,
        output id_rw, id_load, id_store,
        output id_br, id_mc, flush,
        input  stall, hold, fwd_a, fwd_b,
        input  fwd_br_a, fwd_br_b, fwd_m,
        input  stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2,
        input  id_use1, id_use2, id_rd,
        input  id_rw, id_load, id_store,
        input  id_br, id_mc, flush,
        output stall, hold, fwd_a, fwd_b,
        output fwd_br_a, fwd_br_b, fwd_m,
        output stall_cnt
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_match_sel.sv
// Priority search of the post-EX tag entries for one source register.
// Ports: i_e entries 1..N (1 = youngest), i_rs source, o_sel stage or 0.
module fwd_match_sel
    import hazard_pkg::*;
#(
    parameter int N    = 2,
    parameter int SELW = 2
) (
    input  tag_t [N:1]     i_e,
    input  ra_t            i_rs,
    output logic [SELW-1:0] o_sel
);

    // Walk oldest to youngest so the youngest producer overwrites.
    always_comb begin
        o_sel = SELW'(SEL_RF);
        for (int k = N; k >= 1; k--) begin
            if (tag_match(i_e[k], i_rs)) begin
                o_sel = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: tag pipeline EX..WB, bypass selects,
// load-use/branch stalls, multi-cycle hold FSM, saturating stall counter.
// Ports: clk, rst (sync high), bus (slave side of hazard_forward_ctrl_if).
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int FWD_STAGES = 2,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);

    localparam int N    = FWD_STAGES;
    localparam int SELW = sel_w(FWD_STAGES);
    localparam int MCW  = $clog2(MC_LAT);

    tag_t             r_e [0:N];
    mc_state_t        r_state;
    logic [MCW-1:0]   r_mc_cnt;
    logic             r_hold;
    logic [CNT_W-1:0] r_stall_cnt;

    tag_t       w_id_tag;
    tag_t       w_e0_nxt;
    tag_t [N:1] w_old;
    ra_t        w_rs1;
    ra_t        w_rs2;
    logic       w_m0_1, w_m0_2;
    logic       w_m1_1, w_m1_2;
    logic       w_lu, w_br, w_stall;
    logic       w_fwd_m;

    assign w_rs1 = RA_MAX'(bus.id_rs1);
    assign w_rs2 = RA_MAX'(bus.id_rs2);

    always_comb begin
        w_id_tag     = '0;
        w_id_tag.v   = 1'b1;
        w_id_tag.rd  = RA_MAX'(bus.id_rd);
        w_id_tag.rw  = bus.id_rw;
        w_id_tag.ld  = bus.id_load;
        w_id_tag.st  = bus.id_store;
        w_id_tag.mc  = bus.id_mc;
        w_id_tag.rs1 = w_rs1;
        w_id_tag.rs2 = w_rs2;
    end

    assign w_m0_1 = bus.id_use1 & tag_match(r_e[0], w_rs1);
    assign w_m0_2 = bus.id_use2 & tag_match(r_e[0], w_rs2);
    assign w_m1_1 = bus.id_use1 & tag_match(r_e[1], w_rs1);
    assign w_m1_2 = bus.id_use2 & tag_match(r_e[1], w_rs2);

    // Branches resolve in ID: EX results and in-flight load data are late.
    assign w_lu = r_e[0].ld & (w_m0_1 | w_m0_2);
    assign w_br = bus.id_br
                & (w_m0_1 | w_m0_2
                   | (r_e[1].ld & (w_m1_1 | w_m1_2)));
    assign w_stall = bus.id_valid & ~r_hold & (w_lu | w_br);

    // Flush wins over stall: the killed instruction becomes a bubble.
    assign w_e0_nxt = (bus.id_valid & ~w_stall & ~bus.flush)
                    ? w_id_tag : '0;

    always_comb begin
        for (int k = 1; k <= N; k++) begin
            w_old[k] = r_e[k];
        end
    end

    fwd_match_sel #(.N(N), .SELW(SELW)) u_sel_a (
        .i_e   (w_old),
        .i_rs  (r_e[0].rs1),
        .o_sel (bus.fwd_a)
    );

    fwd_match_sel #(.N(N), .SELW(SELW)) u_sel_b (
        .i_e   (w_old),
        .i_rs  (r_e[0].rs2),
        .o_sel (bus.fwd_b)
    );

    generate
        if (N >= 2) begin : g_m2m
            assign w_fwd_m = r_e[1].v & r_e[1].st & r_e[2].ld
                           & tag_match(r_e[2], r_e[1].rs2);
        end else begin : g_no_m2m
            assign w_fwd_m = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= N; k++) begin
                r_e[k] <= '0;
            end
        end else if (!r_hold) begin
            for (int k = 1; k <= N; k++) begin
                r_e[k] <= r_e[k-1];
            end
            r_e[0] <= w_e0_nxt;
        end
    end

    // Arms on the op being loaded into EX, so hold covers its first
    // EX cycle; DONE is the single free cycle that lets it retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mc_cnt <= '0;
            r_hold   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_e0_nxt.v & w_e0_nxt.mc) begin
                        r_state  <= BUSY;
                        r_mc_cnt <= MCW'(MC_LAT - 2);
                        r_hold   <= 1'b1;
                    end else begin
                        r_state  <= IDLE;
                        r_hold   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (r_mc_cnt == '0) begin
                        r_state <= DONE;
                        r_hold  <= 1'b0;
                    end else begin
                        r_mc_cnt <= r_mc_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((w_stall | r_hold) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.hold      = r_hold;
    assign bus.fwd_br_a  = bus.id_valid & bus.id_br & w_m1_1 & ~r_e[1].ld;
    assign bus.fwd_br_b  = bus.id_valid & bus.id_br & w_m1_2 & ~r_e[1].ld;
    assign bus.fwd_m     = w_fwd_m;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios plus random
// instruction streams checked every cycle against a behavioural model.
module tb_hazard_forward_ctrl;

    localparam int FS  = 3;
    localparam int MCL = 4;
    localparam int CW  = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(
        .RA_W(5), .FWD_STAGES(FS), .CNT_W(CW)
    ) bus ();

    hazard_forward_ctrl #(
        .RA_W(5), .FWD_STAGES(FS),
        .MC_LAT(MCL), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: pipeline of instruction records, plus a count of
    // remaining hold cycles and the stall cycle total.
    bit mv   [0:FS];
    int mrd  [0:FS];
    bit mrw  [0:FS];
    bit mld  [0:FS];
    bit mst  [0:FS];
    int mrs2 [0:FS];
    int mrs1 [0:FS];
    int m_hold_left;
    int m_cnt;

    bit e_stall, e_hold;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit mm(input int k, input int r);
        return mv[k] && mrw[k] && mrd[k] != 0 && mrd[k] == r;
    endfunction

    function automatic int fsel(input int r);
        for (int k = 1; k <= FS; k++) begin
            if (mm(k, r)) return k;
        end
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k <= FS; k++) begin
            mv[k] = 0; mrd[k] = 0; mrw[k] = 0; mld[k] = 0;
            mst[k] = 0; mrs1[k] = 0; mrs2[k] = 0;
        end
        m_hold_left = 0;
        m_cnt = 0;
    endtask

    task automatic check_cycle();
        int r1, r2;
        bit u1, u2, src0, src1, lu, br;
        bit bra, brb, m2m;
        @(negedge clk);
        r1 = int'(bus.id_rs1);
        r2 = int'(bus.id_rs2);
        u1 = bus.id_use1;
        u2 = bus.id_use2;
        e_hold = m_hold_left > 0;
        src0 = (u1 && mm(0, r1)) || (u2 && mm(0, r2));
        src1 = (u1 && mm(1, r1)) || (u2 && mm(1, r2));
        lu = mld[0] && src0;
        br = bus.id_br && (src0 || (mld[1] && src1));
        e_stall = bus.id_valid && !e_hold && (lu || br);
        bra = bus.id_valid && bus.id_br && u1
              && mm(1, r1) && !mld[1];
        brb = bus.id_valid && bus.id_br && u2
              && mm(1, r2) && !mld[1];
        m2m = mv[1] && mst[1] && mld[2] && mm(2, mrs2[1]);
        chk("stall", int'(bus.stall), int'(e_stall));
        chk("hold", int'(bus.hold), int'(e_hold));
        chk("fwd_a", int'(bus.fwd_a), fsel(mrs1[0]));
        chk("fwd_b", int'(bus.fwd_b), fsel(mrs2[0]));
        chk("fwd_br_a", int'(bus.fwd_br_a), int'(bra));
        chk("fwd_br_b", int'(bus.fwd_br_b), int'(brb));
        chk("fwd_m", int'(bus.fwd_m), int'(m2m));
        chk("stall_cnt", int'(bus.stall_cnt), m_cnt);
    endtask

    task automatic advance();
        bit issue;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if ((e_stall || e_hold) && m_cnt < CMAX) m_cnt++;
            if (e_hold) begin
                m_hold_left--;
            end else begin
                for (int k = FS; k >= 1; k--) begin
                    mv[k] = mv[k-1]; mrd[k] = mrd[k-1];
                    mrw[k] = mrw[k-1]; mld[k] = mld[k-1];
                    mst[k] = mst[k-1];
                    mrs1[k] = mrs1[k-1]; mrs2[k] = mrs2[k-1];
                end
                issue = bus.id_valid && !e_stall && !bus.flush;
                mv[0]   = issue;
                mrd[0]  = issue ? int'(bus.id_rd) : 0;
                mrw[0]  = issue && bus.id_rw;
                mld[0]  = issue && bus.id_load;
                mst[0]  = issue && bus.id_store;
                mrs1[0] = issue ? int'(bus.id_rs1) : 0;
                mrs2[0] = issue ? int'(bus.id_rs2) : 0;
                if (issue && bus.id_mc) m_hold_left = MCL - 1;
            end
        end
        #1;
    endtask

    task automatic cyc();
        check_cycle();
        advance();
    endtask

    task automatic set_id(
        input bit v, input int rs1, input int rs2,
        input bit u1, input bit u2, input int rd,
        input bit rw, input bit ld, input bit st,
        input bit br, input bit mc
    );
        bus.id_valid = v;
        bus.id_rs1   = 5'(rs1);
        bus.id_rs2   = 5'(rs2);
        bus.id_use1  = u1;
        bus.id_use2  = u2;
        bus.id_rd    = 5'(rd);
        bus.id_rw    = rw;
        bus.id_load  = ld;
        bus.id_store = st;
        bus.id_br    = br;
        bus.id_mc    = mc;
        bus.flush    = 1'b0;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        set_id(1, rs1, rs2, 1, 1, rd, 1, 0, 0, 0, 0);
    endtask

    task automatic lw(input int rd);
        set_id(1, 1, 0, 1, 0, rd, 1, 1, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        nop();
        rst = 1'b1;
        advance();
        advance();
        check_cycle();
        chk("rst_stall", int'(bus.stall), 0);
        chk("rst_hold", int'(bus.hold), 0);
        chk("rst_cnt", int'(bus.stall_cnt), 0);
        rst = 1'b0;
        advance();

        // Youngest of two x5 producers wins.
        alu(5, 1, 2); cyc();
        alu(5, 3, 4); cyc();
        alu(9, 5, 0); cyc();
        nop(); check_cycle();
        chk("t1_fwd_a", int'(bus.fwd_a), 1);
        advance();

        // Load-use on rs2.
        lw(6); cyc();
        alu(10, 1, 6); check_cycle();
        chk("t2_stall", int'(bus.stall), 1);
        advance();
        check_cycle();
        chk("t2_nostall", int'(bus.stall), 0);
        advance();
        nop(); check_cycle();
        chk("t2_fwd_b", int'(bus.fwd_b), 2);
        chk("t2_cnt", int'(bus.stall_cnt), 1);
        advance();

        // Branch on a load: two stalls, then no ID bypass.
        lw(7); cyc();
        set_id(1, 7, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        check_cycle();
        chk("t3_ld_s1", int'(bus.stall), 1);
        advance();
        check_cycle();
        chk("t3_ld_s2", int'(bus.stall), 1);
        advance();
        check_cycle();
        chk("t3_ld_go", int'(bus.stall), 0);
        chk("t3_ld_br", int'(bus.fwd_br_a), 0);
        advance();
        // Branch on an ALU op: one stall, then ID bypass.
        alu(7, 1, 2); cyc();
        set_id(1, 7, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        check_cycle();
        chk("t3_alu_s1", int'(bus.stall), 1);
        advance();
        check_cycle();
        chk("t3_alu_go", int'(bus.stall), 0);
        chk("t3_alu_br", int'(bus.fwd_br_a), 1);
        advance();

        // Mem-to-mem: sw data x8 directly behind lw x8.
        lw(8); cyc();
        set_id(1, 1, 8, 1, 0, 0, 0, 0, 1, 0, 0); cyc();
        nop(); cyc();
        check_cycle();
        chk("t4_fwd_m", int'(bus.fwd_m), 1);
        advance();
        // Writes to x0 are never forwarded.
        alu(0, 1, 2); cyc();
        alu(3, 0, 0); cyc();
        nop(); check_cycle();
        chk("t4_x0_a", int'(bus.fwd_a), 0);
        chk("t4_x0_b", int'(bus.fwd_b), 0);
        advance();

        // Multi-cycle op, dependent add behind it.
        set_id(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 1); cyc();
        alu(12, 11, 0);
        for (int i = 0; i < MCL - 1; i++) begin
            check_cycle();
            chk("t5_hold", int'(bus.hold), 1);
            advance();
        end
        check_cycle();
        chk("t5_done", int'(bus.hold), 0);
        advance();
        nop(); check_cycle();
        chk("t5_fwd_a", int'(bus.fwd_a), 1);
        chk("t5_sat", int'(bus.stall_cnt), CMAX);
        advance();
        // Reset while busy.
        set_id(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 1); cyc();
        nop(); check_cycle();
        chk("t5_busy", int'(bus.hold), 1);
        advance();
        rst = 1'b1; cyc();
        rst = 1'b0;
        check_cycle();
        chk("t5_rst_hold", int'(bus.hold), 0);
        chk("t5_rst_cnt", int'(bus.stall_cnt), 0);
        advance();

        // Flush beats stall: the flushed load must not reach EX.
        lw(6); cyc();
        set_id(1, 6, 0, 1, 0, 13, 1, 1, 0, 0, 0);
        bus.flush = 1'b1;
        check_cycle();
        chk("t6_fl_stall", int'(bus.stall), 1);
        advance();
        alu(14, 13, 0); check_cycle();
        chk("t6_bubble", int'(bus.stall), 0);
        advance();

        // Back-to-back multi-cycle ops, then saturation.
        set_id(1, 1, 2, 1, 1, 15, 1, 0, 0, 0, 1); cyc();
        set_id(1, 1, 2, 1, 1, 16, 1, 0, 0, 0, 1);
        for (int i = 0; i < MCL; i++) cyc();
        nop(); check_cycle();
        chk("t6_rearm", int'(bus.hold), 1);
        advance();
        for (int i = 0; i < MCL; i++) cyc();
        lw(9); cyc();
        alu(17, 1, 9); check_cycle();
        chk("t6_lu", int'(bus.stall), 1);
        advance();
        nop(); check_cycle();
        chk("t6_sat", int'(bus.stall_cnt), CMAX);
        advance();

        // Random instruction stream on a small register window.
        for (int i = 0; i < 2000; i++) begin
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 15) == 0);
            bus.flush = $urandom_range(0, 7) == 0;
            rst = $urandom_range(0, 127) == 0;
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
